// File: rtl/versatile_fifo_pkg.sv
// Shared constants, buffer-operation encoding and pointer arithmetic for the
// versatile FIFO read side.
package versatile_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 11;
    localparam int MAX_PTR_WIDTH      = 32;

    typedef enum logic [1:0] {
        SKID_HOLD = 2'b00,
        SKID_POP  = 2'b01,
        SKID_LOAD = 2'b10,
        SKID_SWAP = 2'b11
    } skid_op_e;

    // Words between two wrapping pointers of ptr_width bits.
    function automatic logic [MAX_PTR_WIDTH-1:0] ptr_diff(
        input logic [MAX_PTR_WIDTH-1:0] wr,
        input logic [MAX_PTR_WIDTH-1:0] rd,
        input int                       ptr_width
    );
        logic [MAX_PTR_WIDTH-1:0] mask;
        if (ptr_width >= MAX_PTR_WIDTH)
            mask = '1;
        else
            mask = (MAX_PTR_WIDTH'(1) << ptr_width) - MAX_PTR_WIDTH'(1);
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/versatile_fifo_rd_skid.sv
// Two-entry output buffer for the FIFO read side; the head entry drives the
// consumer data directly from a register.
module versatile_fifo_rd_skid
    import versatile_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] tail_data;
    skid_op_e              op;

    assign op = skid_op_e'({load, pop});

    // A load with a simultaneous pop keeps the count; which entry it lands in
    // depends on whether the tail was occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            head_data <= '0;
            tail_data <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case (op)
                SKID_POP: begin
                    head_data <= tail_data;
                    count     <= count - 2'd1;
                end
                SKID_LOAD: begin
                    if (count == 2'd0)
                        head_data <= load_data;
                    else
                        tail_data <= load_data;
                    count <= count + 2'd1;
                end
                SKID_SWAP: begin
                    if (count == 2'd1) begin
                        head_data <= load_data;
                    end else begin
                        head_data <= tail_data;
                        tail_data <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/versatile_fifo_rd_ctrl.sv
// FIFO read controller: issues RAM reads ahead of a 2-entry output buffer.
// Define VERSATILE_FIFO_RD_LEVEL_EN to add the registered 'level' output.
module versatile_fifo_rd_ctrl
    import versatile_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH-1:0] ram_adr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic                  empty
`ifdef VERSATILE_FIFO_RD_LEVEL_EN
    , output logic [ADDR_WIDTH:0] level
`endif
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic             in_flight;
    logic [1:0]       skid_count;
    logic             pop;
    logic             issue;
    logic             load;
    logic [2:0]       occupancy;
    logic [PTR_W-1:0] rd_ptr_next;
    logic             in_flight_next;

    assign pop       = m_valid & m_ready;
    assign occupancy = {1'b0, skid_count} + {2'b00, in_flight};
    // Issue only if the word can be absorbed by the buffer when it lands.
    assign issue     = !flush && (rd_ptr != wr_ptr) && (occupancy < (3'd2 + {2'b00, pop}));
    assign load      = in_flight & ~flush;

    assign ram_adr = rd_ptr[ADDR_WIDTH-1:0];
    assign m_valid = (skid_count != 2'd0);
    assign empty   = (rd_ptr == wr_ptr) && !in_flight && (skid_count == 2'd0);

    always_comb begin
        rd_ptr_next    = rd_ptr + PTR_W'(issue);
        in_flight_next = issue;
        if (flush) begin
            rd_ptr_next    = wr_ptr;
            in_flight_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            in_flight <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr_next;
            in_flight <= in_flight_next;
        end
    end

    versatile_fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (ram_q),
        .pop       (pop),
        .flush     (flush),
        .count     (skid_count),
        .head_data (m_data)
    );

`ifdef VERSATILE_FIFO_RD_LEVEL_EN
    logic [1:0]       count_next;
    logic [PTR_W-1:0] level_next;

    // Level tracks the state being entered so it agrees with the other outputs.
    always_comb begin
        count_next = skid_count + 2'(load) - 2'(pop);
        if (flush)
            count_next = 2'd0;
        level_next = PTR_W'(ptr_diff(MAX_PTR_WIDTH'(wr_ptr), MAX_PTR_WIDTH'(rd_ptr_next), PTR_W))
                   + PTR_W'(in_flight_next) + PTR_W'(count_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            level <= '0;
        else
            level <= level_next;
    end
`endif

endmodule

// File: tb/tb_versatile_fifo_rd_ctrl.sv
// Self-checking bench for versatile_fifo_rd_ctrl: directed scenarios plus a
// randomized run scored against a queue of written-but-undelivered words.
module tb_versatile_fifo_rd_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 11;
    localparam int PW  = AW + 1;
    localparam int AW3 = 3;
    localparam int PW3 = AW3 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [PW-1:0] wr_ptr;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_q;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] m_data;
    logic          m_valid, m_ready, flush, empty;

    logic [PW3-1:0] wr_ptr3, rd_ptr3;
    logic [AW3-1:0] ram_adr3;
    logic [DW-1:0]  ram_q3, m_data3;
    logic           m_valid3, m_ready3, flush3, empty3;

`ifdef VERSATILE_FIFO_RD_LEVEL_EN
    logic [PW-1:0]  level;
    logic [PW3-1:0] level3;
`endif

    logic [DW-1:0] mem  [0:(1<<AW)-1];
    logic [DW-1:0] mem3 [0:(1<<AW3)-1];

    always @(posedge clk) ram_q  <= mem[ram_adr];
    always @(posedge clk) ram_q3 <= mem3[ram_adr3];

    versatile_fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_ptr(wr_ptr), .ram_adr(ram_adr), .ram_q(ram_q),
        .rd_ptr(rd_ptr), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush(flush), .empty(empty)
`ifdef VERSATILE_FIFO_RD_LEVEL_EN
        , .level(level)
`endif
    );

    versatile_fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW3)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_ptr(wr_ptr3), .ram_adr(ram_adr3), .ram_q(ram_q3),
        .rd_ptr(rd_ptr3), .m_data(m_data3), .m_valid(m_valid3), .m_ready(m_ready3),
        .flush(flush3), .empty(empty3)
`ifdef VERSATILE_FIFO_RD_LEVEL_EN
        , .level(level3)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_ptr = '0; wr_ptr3 = '0; flush = 1'b0; flush3 = 1'b0;
        m_ready = 1'b0; m_ready3 = 1'b0;
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic write_word(input logic [DW-1:0] v);
        mem[wr_ptr[AW-1:0]] = v;
        wr_ptr = wr_ptr + 1'b1;
        exp_q.push_back(v);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_ptr = '0; wr_ptr3 = '0; flush = 1'b0; flush3 = 1'b0;
        m_ready = 1'b0; m_ready3 = 1'b0;
        #2;
        checks++; if (rd_ptr !== 12'd0) begin errors++; $display("FAIL reset_rd_ptr: got %h want 0", rd_ptr); end
        checks++; if (ram_adr !== 11'd0) begin errors++; $display("FAIL reset_ram_adr: got %h want 0", ram_adr); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (rd_ptr3 !== 4'd0) begin errors++; $display("FAIL reset_rd_ptr3: got %h want 0", rd_ptr3); end
`ifdef VERSATILE_FIFO_RD_LEVEL_EN
        checks++; if (level !== 12'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
`endif
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_single();
        do_reset();
        mem[0] = 8'hA5;
        wr_ptr = 12'd1;
        step(1);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", m_valid); end
        step(1);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", m_valid); end
        checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", m_data); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_not_empty: got %b want 0", empty); end
        m_ready = 1'b1;
        step(1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop: got %b want 1", empty); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after_pop: got %b want 0", m_valid); end
    endtask

    task automatic test_stream();
        int waited;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) write_word(8'(i));
        waited = 0;
        while (!m_valid && waited < 8) begin step(1); waited++; end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin
                errors++;
                $display("FAIL stream_word%0d: got valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            step(1);
        end
        checks++; if (rd_ptr !== 12'd16) begin errors++; $display("FAIL stream_rd_ptr: got %0d want 16", rd_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b want 1", empty); end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(8'h30 + 8'(i));
        step(6);
        checks++; if (rd_ptr !== 12'd2) begin errors++; $display("FAIL bp_rd_ptr: got %0d want 2", rd_ptr); end
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h30) begin errors++; $display("FAIL bp_hold: got valid=%b data=%h want valid=1 data=30", m_valid, m_data); end
        step(3);
        checks++; if (m_data !== 8'h30) begin errors++; $display("FAIL bp_stable: got %h want 30", m_data); end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin
                errors++;
                $display("FAIL bp_release%0d: got valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            step(1);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_empty: got %b want 1", empty); end
    endtask

    task automatic test_wrap();
        int a;
        do_reset();
        m_ready3 = 1'b1;
        for (int i = 0; i < 6; i++) mem3[i] = 8'(i);
        wr_ptr3 = 4'd6;
        step(12);
        checks++; if (rd_ptr3 !== 4'd6 || empty3 !== 1'b1) begin errors++; $display("FAIL wrap_prefill: got rd_ptr=%0d empty=%b want 6 1", rd_ptr3, empty3); end
        for (int i = 0; i < 4; i++) begin
            a = (6 + i) % 8;
            mem3[a] = 8'h80 + 8'(a);
            exp_q.push_back(8'h80 + 8'(a));
        end
        wr_ptr3 = 4'd10;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (m_valid3 && m_ready3) begin
                checks++;
                if (m_data3 !== exp_q[0]) begin errors++; $display("FAIL wrap_data: got %h want %h", m_data3, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            step(1);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_count: got %0d undelivered want 0", exp_q.size()); end
        checks++; if (rd_ptr3 !== 4'b1010) begin errors++; $display("FAIL wrap_rd_ptr: got %b want 1010", rd_ptr3); end
    endtask

    task automatic test_flush();
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) write_word(8'h40 + 8'(i));
        step(6);
`ifdef VERSATILE_FIFO_RD_LEVEL_EN
        checks++; if (level !== 12'd7) begin errors++; $display("FAIL flush_level_before: got %0d want 7", level); end
`endif
        checks++; if (m_valid !== 1'b1 || rd_ptr !== 12'd2) begin errors++; $display("FAIL flush_setup: got valid=%b rd_ptr=%0d want 1 2", m_valid, rd_ptr); end
        flush = 1'b1;
        m_ready = 1'b1;
        step(1);
        flush = 1'b0;
        m_ready = 1'b0;
        exp_q.delete();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", m_valid); end
        checks++; if (rd_ptr !== 12'd7) begin errors++; $display("FAIL flush_rd_ptr: got %0d want 7", rd_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b want 1", empty); end
`ifdef VERSATILE_FIFO_RD_LEVEL_EN
        checks++; if (level !== 12'd0) begin errors++; $display("FAIL flush_level: got %0d want 0", level); end
`endif
        write_word(8'hC3);
        m_ready = 1'b1;
        step(2);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'hC3) begin errors++; $display("FAIL flush_next_word: got valid=%b data=%h want 1 c3", m_valid, m_data); end
        step(1);
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_word(8'h61 + 8'(i));
        step(4);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h61) begin errors++; $display("FAIL rstmid_setup: got valid=%b data=%h want 1 61", m_valid, m_data); end
        rst_n = 1'b0;
        wr_ptr = '0;
        exp_q.delete();
        #1;
        checks++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin errors++; $display("FAIL rstmid_outputs: got valid=%b data=%h want 0 00", m_valid, m_data); end
        checks++; if (rd_ptr !== 12'd0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_ptr: got rd_ptr=%0d empty=%b want 0 1", rd_ptr, empty); end
        step(1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale%0d: got valid=%b want 0", i, m_valid); end
        end
        write_word(8'h5A);
        m_ready = 1'b1;
        step(2);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h5A) begin errors++; $display("FAIL rstmid_fresh: got valid=%b data=%h want 1 5a", m_valid, m_data); end
        step(1);
        exp_q.delete();
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            checks++;
            if (empty !== (exp_q.size() == 0)) begin errors++; $display("FAIL rand_empty@%0d: got %b want %b", c, empty, exp_q.size() == 0); end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious@%0d: got data=%h want no word", c, m_data);
                end else begin
                    if (m_data !== exp_q[0]) begin errors++; $display("FAIL rand_data@%0d: got %h want %h", c, m_data, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
            n = $urandom_range(0, 2);
            if (exp_q.size() < 40) repeat (n) write_word(8'($urandom));
            step(1);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            if (m_valid) begin
                checks++;
                if (m_data !== exp_q[0]) begin errors++; $display("FAIL rand_drain: got %h want %h", m_data, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            step(1);
        end
        checks++; if (exp_q.size() != 0 || empty !== 1'b1) begin errors++; $display("FAIL rand_final: got %0d left empty=%b want 0 1", exp_q.size(), empty); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/versatile_fifo_rd_ctrl.md
VERSATILE_FIFO_RD_CTRL -- requirements
Module: versatile_fifo_rd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the RAM word and output data width.
REQ-002 Parameter ADDR_WIDTH, default 11, SHALL set the RAM address width; pointers SHALL be ADDR_WIDTH+1 bits.
REQ-003 clk  in  1  SHALL be the single clock; all logic rising-edge; reset is asynchronous and active-low.
REQ-004 rst_n  in  1  SHALL be the asynchronous active-low reset.
REQ-005 wr_ptr  in  ADDR_WIDTH+1  SHALL be the writer's next-write pointer, binary with wrap bit, same clock domain.
REQ-006 ram_adr  out  ADDR_WIDTH  SHALL drive the RAM read-port address.
REQ-007 ram_q  in  DATA_WIDTH  SHALL be the RAM read data, registered in the RAM one clk after ram_adr.
REQ-008 rd_ptr  out  ADDR_WIDTH+1  SHALL be the read pointer returned to the writer for its full calculation.
REQ-009 m_data  out  DATA_WIDTH  SHALL be the output word.
REQ-010 m_valid  out  1  SHALL flag m_data valid.
REQ-011 m_ready  in  1  SHALL be consumer acceptance; transfer when m_valid and m_ready are both high.
REQ-012 flush  in  1  SHALL synchronously discard all unread data.
REQ-013 empty  out  1  SHALL be high when no word is stored, in flight or buffered.

Function
REQ-014 ram_adr SHALL equal rd_ptr[ADDR_WIDTH-1:0] combinationally.
REQ-015 A read SHALL issue in a cycle when rd_ptr != wr_ptr and (buffered + in-flight - pop) < 2, where pop = m_valid & m_ready.
REQ-016 On issue, rd_ptr SHALL increment modulo 2^(ADDR_WIDTH+1) and the in-flight flag SHALL set at the same edge.
REQ-017 The word for an in-flight read SHALL be loaded from ram_q into the 2-entry output buffer at the next edge; in-flight then clears unless another read issued.
REQ-018 Latency: wr_ptr changing at edge k into an empty block SHALL give m_valid high after edge k+2 with the corresponding word.
REQ-019 With m_ready held high and data available, throughput SHALL be one word per clk with no bubbles.
REQ-020 m_data/m_valid SHALL be registered; m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-021 Words SHALL be delivered in strict address order with none lost or duplicated across wrap from address 2^ADDR_WIDTH-1 to 0.
REQ-022 Buffer full (2 entries) SHALL block issue; a pop in the same cycle SHALL permit issue.
REQ-023 flush SHALL at the next edge set rd_ptr=wr_ptr, clear in-flight and buffer, drive m_valid=0; flush overrides issue and pop in that cycle.
REQ-024 empty SHALL be (rd_ptr==wr_ptr) & !in-flight & buffer count==0, combinational from registers.
REQ-025 Writer SHALL guarantee wr_ptr - rd_ptr <= 2^ADDR_WIDTH; behaviour outside this is undefined.

Reset
REQ-026 While rst_n=0: rd_ptr=0, ram_adr=0, in-flight=0, buffer count=0, m_valid=0, m_data=0, empty=1, level=0.
REQ-027 Reset asserted mid-transfer SHALL discard in-flight and buffered words with no output glitch after deassertion.

Configuration
REQ-028 With VERSATILE_FIFO_RD_LEVEL_EN defined, output level (ADDR_WIDTH+1 bits) SHALL equal (wr_ptr - rd_ptr) + in-flight + buffer count, registered, updated each clk.
REQ-029 Without VERSATILE_FIFO_RD_LEVEL_EN, the level port and its logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-030 Package versatile_fifo_pkg SHALL hold default width constants and the pointer-difference function.
REQ-031 The 2-entry output buffer SHALL be sub-module versatile_fifo_rd_skid (load, pop, flush, count, head data).

Verification
REQ-032 Reset, then wr_ptr 0->1 with RAM[0]=0xA5 -> m_valid high 2 clk later, m_data=0xA5, empty low until pop.
REQ-033 Preload 16 words 0x00..0x0F, m_ready=1 -> 16 consecutive transfers on consecutive clk, rd_ptr=16, empty=1.
REQ-034 Preload 4 words, m_ready=0 -> exactly 2 reads issue, rd_ptr=2, m_data held=word0; release -> words 0..3 in order.
REQ-035 ADDR_WIDTH=3, rd_ptr=6, write 4 words -> addresses 6,7,0,1 delivered in order; rd_ptr=10 (4'b1010).
REQ-036 Flush with 5 stored and 2 buffered -> next clk m_valid=0, rd_ptr=wr_ptr, empty=1, level=0 (macro on).
REQ-037 rst_n pulsed low while m_valid=1 -> outputs reset immediately; no stale word after release.
